// File: rtl/frac_clken_pkg.sv
// Shared constants and helpers for the fractional clock-enable generator.
// Increment values can be derived from frequencies with calc_inc.
package frac_clken_pkg;

    localparam int MAX_CH   = 8;
    localparam int CFG_CH_W = 3;

    // Rounded increment for a target strobe rate: f_target * 2^acc_w / f_ref.
    function automatic logic [63:0] calc_inc(
        input longint unsigned f_target,
        input longint unsigned f_ref,
        input int              acc_w
    );
        longint unsigned num;
        num      = (f_target << acc_w) + (f_ref >> 1);
        calc_inc = num / f_ref;
    endfunction

endpackage

// File: rtl/frac_clken_ch.sv
// One phase-accumulator channel with a double-buffered increment.
// A new rate takes effect only at a carry or when the accumulator is idle/cleared.
module frac_clken_ch
    import frac_clken_pkg::*;
#(
    parameter int               ACC_W    = 32,
    parameter logic [ACC_W-1:0] INIT_INC = '0
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             wr_i,
    input  logic [ACC_W-1:0] wr_data_i,
    output logic             ce_o,
    output logic             pending_o,
    output logic             inc_chg_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic             pv_q, pv_d;
    logic             ce_q, ce_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        carry  = sum[ACC_W];
        // Carry uses the old increment, so the strobe this cycle is old-rate.
        apply  = pv_q && (carry || (inc_q == '0) || !en_i || sync_i);
        acc_d  = acc_q;
        inc_d  = inc_q;
        pend_d = pend_q;
        pv_d   = pv_q;
        ce_d   = ce_q;

        // A write in an apply cycle defers to the next qualifying event.
        if (wr_i) begin
            pend_d = wr_data_i;
            pv_d   = 1'b1;
        end else if (apply) begin
            inc_d = pend_q;
            pv_d  = 1'b0;
        end

        if (sync_i || !en_i) begin
            acc_d = '0;
            ce_d  = 1'b0;
        end else begin
            acc_d = sum[ACC_W-1:0];
            ce_d  = carry;
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            inc_q  <= INIT_INC;
            pend_q <= '0;
            pv_q   <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            ce_q   <= ce_d;
        end
    end

    assign ce_o      = ce_q;
    assign pending_o = pv_q;
    assign inc_chg_o = (inc_d != inc_q);

endmodule

// File: rtl/frac_clken_gen.sv
// NUM_CH fractional-rate clock-enable strobes from one clock, with a lock flag
// that stays low until rates and enables have been quiet for LOCK_CYCLES.
module frac_clken_gen
    import frac_clken_pkg::*;
#(
    parameter int                      NUM_CH      = 3,
    parameter int                      ACC_W       = 32,
    parameter int                      LOCK_CYCLES = 1024,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INC    = '0
) (
    input  logic                refclk,
    input  logic                rst_n,
    input  logic [NUM_CH-1:0]   ch_en,
    input  logic                sync_req,
    input  logic                cfg_we,
    input  logic [CFG_CH_W-1:0] cfg_ch,
    input  logic [ACC_W-1:0]    cfg_inc,
    output logic [NUM_CH-1:0]   cfg_pending,
    output logic [NUM_CH-1:0]   ce_out,
    output logic                locked
);

    localparam int                CNT_W    = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LOCK_MAX = CNT_W'(LOCK_CYCLES);

    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] inc_chg;
    logic [NUM_CH-1:0] en_q;
    logic              en_seen_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              locked_q;
    logic              disturb;

    // Writes to channels at or beyond NUM_CH select nothing and are dropped.
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = cfg_we && (cfg_ch == CFG_CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        frac_clken_ch #(
            .ACC_W    (ACC_W),
            .INIT_INC (INIT_INC[g*ACC_W +: ACC_W])
        ) u_ch (
            .refclk    (refclk),
            .rst_n     (rst_n),
            .en_i      (ch_en[g]),
            .sync_i    (sync_req),
            .wr_i      (wr_sel[g]),
            .wr_data_i (cfg_inc),
            .ce_o      (ce_out[g]),
            .pending_o (cfg_pending[g]),
            .inc_chg_o (inc_chg[g])
        );
    end

    // First cycle out of reset has no enable history to compare against.
    always_comb begin
        disturb = sync_req || (|inc_chg) || (en_seen_q && (ch_en != en_q));
        cnt_d   = cnt_q;
        if (disturb) begin
            cnt_d = '0;
        end else if (cnt_q != LOCK_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            locked_q  <= 1'b0;
            en_q      <= '0;
            en_seen_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            locked_q  <= (cnt_q == LOCK_MAX);
            en_q      <= ch_en;
            en_seen_q <= 1'b1;
        end
    end

    assign locked = locked_q;

endmodule
